// File: rtl/blockade_pkg.sv
// blockade_pkg: shared direction type, joystick bit map and direction helpers.
package blockade_pkg;
  typedef enum logic [2:0] {NONE, UP, DOWN, LEFT, RIGHT} dir_t;
  localparam int JOY_RIGHT = 0;
  localparam int JOY_LEFT  = 1;
  localparam int JOY_DOWN  = 2;
  localparam int JOY_UP    = 3;
  localparam int JOY_COIN  = 4;
  localparam int JOY_START = 5;
  function automatic logic [3:0] dir_to_n(input dir_t d);
    return ~{d == UP, d == DOWN, d == LEFT, d == RIGHT};
  endfunction
  // b is {up,down,left,right}, which matches the joystick word order [3:0]
  function automatic dir_t pick_dir(input logic [3:0] b);
    return b[3] ? UP : b[2] ? DOWN : b[1] ? LEFT : b[0] ? RIGHT : NONE;
  endfunction
endpackage

// File: rtl/blockade_dir_resolver.sv
// blockade_dir_resolver: reduces one player's stick to a single 4-way direction, last press wins.
module blockade_dir_resolver
  import blockade_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] joy_dir,
  output dir_t       dir
);
  logic [3:0] r_prev;
  logic [3:0] w_rise;
  logic       w_held;
  dir_t       r_dir;
  dir_t       w_next;
  always_comb begin
    w_rise = joy_dir & ~r_prev;
    w_held = |(joy_dir & ~dir_to_n(r_dir));
    w_next = |w_rise ? pick_dir(w_rise) : w_held ? r_dir : pick_dir(joy_dir);
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_prev <= '0;
      r_dir  <= NONE;
    end else begin
      r_prev <= joy_dir;
      r_dir  <= w_next;
    end
  end
  assign dir = r_dir;
endmodule

// File: rtl/blockade_inputs.sv
// blockade_inputs: turns the two joystick words into the core's active-low in0/in1/in2 bytes.
module blockade_inputs
  import blockade_pkg::*;
#(
  parameter int COIN_FRAMES = 3,
  parameter int CNT_W       = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] joystick_0,
  input  logic [15:0] joystick_1,
  input  logic        vblank,
  output logic [7:0]  in0,
  output logic [7:0]  in1,
  output logic [7:0]  in2,
  output logic        coin_led
);
  logic             r_vb;
  logic [5:0]       r_joy0;
  logic [5:0]       r_joy1;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_vb_rise;
  logic             w_coin_edge;
  logic             w_unused;
  dir_t             w_dir0;
  dir_t             w_dir1;
  assign w_unused = ^{joystick_0[15:6], joystick_1[15:6]};
  blockade_dir_resolver u_dir0 (
    .clk     (clk),
    .reset_n (reset_n),
    .joy_dir (r_joy0[JOY_UP:JOY_RIGHT]),
    .dir     (w_dir0)
  );
  blockade_dir_resolver u_dir1 (
    .clk     (clk),
    .reset_n (reset_n),
    .joy_dir (r_joy1[JOY_UP:JOY_RIGHT]),
    .dir     (w_dir1)
  );
  // a fresh press only arms an idle counter; presses during a stretch are dropped
  always_comb begin
    w_vb_rise   = vblank & ~r_vb;
    w_coin_edge = (joystick_0[JOY_COIN] | joystick_1[JOY_COIN]) & ~(r_joy0[JOY_COIN] | r_joy1[JOY_COIN]);
    w_cnt_nxt   = (w_coin_edge && r_cnt == '0) ? CNT_W'(COIN_FRAMES) :
                  (w_vb_rise && r_cnt != '0) ? r_cnt - 1'b1 : r_cnt;
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_vb     <= 1'b0;
      r_joy0   <= '0;
      r_joy1   <= '0;
      r_cnt    <= '0;
      in0      <= 8'hFF;
      in1      <= 8'hFF;
      in2      <= 8'hFF;
      coin_led <= 1'b0;
    end else begin
      r_vb     <= vblank;
      r_joy0   <= joystick_0[5:0];
      r_joy1   <= joystick_1[5:0];
      r_cnt    <= w_cnt_nxt;
      in0      <= {~(r_cnt != '0), 7'h7F};
      coin_led <= r_cnt != '0;
      if (w_vb_rise) begin
        in1 <= {dir_to_n(w_dir1), dir_to_n(w_dir0)};
        in2 <= {6'h3F, ~r_joy1[JOY_START], ~r_joy0[JOY_START]};
      end
    end
  end
endmodule

// File: tb/tb_blockade_inputs.sv
// tb_blockade_inputs: directed stimulus with a queued-expectation scoreboard checked on the falling edge.
module tb_blockade_inputs;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        vblank = 1'b0;
  logic [15:0] j0 = '0;
  logic [15:0] j1 = '0;
  logic [7:0]  in0, in1, in2;
  logic        coin_led;
  typedef struct {
    int          cyc;
    string       name;
    logic [7:0]  e0;
    logic [7:0]  e1;
    logic [7:0]  e2;
    logic        led;
  } exp_t;
  exp_t q[$];
  exp_t m_e;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  blockade_inputs #(.COIN_FRAMES(3), .CNT_W(4)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .joystick_0 (j0),
    .joystick_1 (j1),
    .vblank     (vblank),
    .in0        (in0),
    .in1        (in1),
    .in2        (in2),
    .coin_led   (coin_led)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      m_e = q.pop_front();
      checks++;
      if (in0 !== m_e.e0 || in1 !== m_e.e1 || in2 !== m_e.e2 || coin_led !== m_e.led) begin
        errors++;
        $display("FAIL %s: got in0=%h in1=%h in2=%h led=%b, want in0=%h in1=%h in2=%h led=%b",
                 m_e.name, in0, in1, in2, coin_led, m_e.e0, m_e.e1, m_e.e2, m_e.led);
      end
    end
  end
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic push_exp(input string name, input logic [7:0] e0, input logic [7:0] e1,
                          input logic [7:0] e2, input logic led);
    q.push_back('{cyc, name, e0, e1, e2, led});
  endtask
  task automatic vb_pulse();
    vblank = 1'b1;
    tick(1);
    vblank = 1'b0;
    tick(1);
  endtask
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
  initial begin
    j0 = 16'h003F;
    j1 = 16'h003F;
    tick(2);
    push_exp("reset", 8'hFF, 8'hFF, 8'hFF, 1'b0);
    reset_n = 1'b1;
    j0 = '0;
    j1 = '0;
    tick(5);
    push_exp("idle_no_vblank", 8'hFF, 8'hFF, 8'hFF, 1'b0);
    vb_pulse();
    push_exp("neutral_frame", 8'hFF, 8'hFF, 8'hFF, 1'b0);
    j0[3] = 1'b1;
    tick(3);
    j0[0] = 1'b1;
    tick(3);
    vb_pulse();
    push_exp("p1_last_right", 8'hFF, 8'hFE, 8'hFF, 1'b0);
    j0[0] = 1'b0;
    tick(3);
    vb_pulse();
    push_exp("p1_back_up", 8'hFF, 8'hF7, 8'hFF, 1'b0);
    j0[3] = 1'b0;
    j0[1] = 1'b1;
    tick(4);
    push_exp("in1_frame_hold", 8'hFF, 8'hF7, 8'hFF, 1'b0);
    vb_pulse();
    push_exp("p1_left", 8'hFF, 8'hFD, 8'hFF, 1'b0);
    j0 = '0;
    tick(3);
    vb_pulse();
    push_exp("p1_none", 8'hFF, 8'hFF, 8'hFF, 1'b0);
    j1[3] = 1'b1;
    j1[1] = 1'b1;
    tick(3);
    vb_pulse();
    push_exp("p2_up_wins", 8'hFF, 8'h7F, 8'hFF, 1'b0);
    j0[3] = 1'b1;
    j0[2] = 1'b1;
    tick(3);
    vb_pulse();
    push_exp("p1_opposing", 8'hFF, 8'h77, 8'hFF, 1'b0);
    j0[3] = 1'b0;
    tick(3);
    vb_pulse();
    push_exp("p1_down_after_up", 8'hFF, 8'h7B, 8'hFF, 1'b0);
    j0 = '0;
    j1 = '0;
    tick(3);
    vb_pulse();
    push_exp("all_released", 8'hFF, 8'hFF, 8'hFF, 1'b0);
    j0[1] = 1'b1;
    vblank = 1'b1;
    tick(1);
    vblank = 1'b0;
    tick(1);
    push_exp("dir_latency", 8'hFF, 8'hFF, 8'hFF, 1'b0);
    vb_pulse();
    push_exp("dir_after_latency", 8'hFF, 8'hFD, 8'hFF, 1'b0);
    j0 = '0;
    tick(3);
    vb_pulse();
    j0[5] = 1'b1;
    tick(3);
    push_exp("start1_midframe", 8'hFF, 8'hFF, 8'hFF, 1'b0);
    vb_pulse();
    push_exp("start1_latched", 8'hFF, 8'hFF, 8'hFE, 1'b0);
    j1[5] = 1'b1;
    vblank = 1'b1;
    tick(1);
    push_exp("start2_coincident", 8'hFF, 8'hFF, 8'hFE, 1'b0);
    vblank = 1'b0;
    tick(1);
    vb_pulse();
    push_exp("start2_latched", 8'hFF, 8'hFF, 8'hFC, 1'b0);
    j0 = '0;
    j1 = '0;
    tick(2);
    vb_pulse();
    push_exp("starts_released", 8'hFF, 8'hFF, 8'hFF, 1'b0);
    j0[4] = 1'b1;
    tick(1);
    push_exp("coin_edge_cycle", 8'hFF, 8'hFF, 8'hFF, 1'b0);
    j0[4] = 1'b0;
    tick(1);
    push_exp("coin_asserted", 8'h7F, 8'hFF, 8'hFF, 1'b1);
    vb_pulse();
    push_exp("coin_frame1", 8'h7F, 8'hFF, 8'hFF, 1'b1);
    vb_pulse();
    push_exp("coin_frame2", 8'h7F, 8'hFF, 8'hFF, 1'b1);
    vb_pulse();
    push_exp("coin_expired", 8'hFF, 8'hFF, 8'hFF, 1'b0);
    j0[4] = 1'b1;
    tick(1);
    j0[4] = 1'b0;
    tick(1);
    push_exp("coin2_start", 8'h7F, 8'hFF, 8'hFF, 1'b1);
    vb_pulse();
    j1[4] = 1'b1;
    tick(1);
    j1[4] = 1'b0;
    tick(1);
    vb_pulse();
    push_exp("retrigger_ignored", 8'h7F, 8'hFF, 8'hFF, 1'b1);
    vb_pulse();
    push_exp("retrigger_total3", 8'hFF, 8'hFF, 8'hFF, 1'b0);
    j0[4] = 1'b1;
    tick(2);
    push_exp("coin_hold_start", 8'h7F, 8'hFF, 8'hFF, 1'b1);
    vb_pulse();
    vb_pulse();
    vb_pulse();
    tick(2);
    push_exp("coin_hold_no_retrigger", 8'hFF, 8'hFF, 8'hFF, 1'b0);
    j0[4] = 1'b0;
    tick(2);
    j0[4] = 1'b1;
    vblank = 1'b1;
    tick(1);
    j0[4] = 1'b0;
    vblank = 1'b0;
    tick(1);
    push_exp("coin_vb_same", 8'h7F, 8'hFF, 8'hFF, 1'b1);
    vb_pulse();
    vb_pulse();
    push_exp("coin_vb_same_2", 8'h7F, 8'hFF, 8'hFF, 1'b1);
    vb_pulse();
    push_exp("coin_vb_same_end", 8'hFF, 8'hFF, 8'hFF, 1'b0);
    j0[4] = 1'b1;
    tick(1);
    j0[4] = 1'b0;
    j0[3] = 1'b1;
    tick(3);
    vb_pulse();
    push_exp("pre_reset", 8'h7F, 8'hF7, 8'hFF, 1'b1);
    reset_n = 1'b0;
    j0 = '0;
    tick(1);
    push_exp("reset_abort", 8'hFF, 8'hFF, 8'hFF, 1'b0);
    reset_n = 1'b1;
    tick(3);
    push_exp("after_reset_abort", 8'hFF, 8'hFF, 8'hFF, 1'b0);
    vb_pulse();
    push_exp("no_stretch_resume", 8'hFF, 8'hFF, 8'hFF, 1'b0);
    tick(2);
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard: %0d expectations never checked", q.size());
    end
    if (checks < 12) begin
      errors++;
      $display("FAIL scoreboard: only %0d checks ran", checks);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    if (errors != 0) $fatal(1);
    $finish;
  end
endmodule
